// File: rtl/upower_mc_control.sv
// Multi-cycle control sequencer for a micro-coded CPU datapath: fetch, decode,
// execute, memory and write-back phases with ack timeouts and a retire counter.
module upower_mc_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr,
  output logic        alu_en,
  input  logic        alu_branch,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        reg_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic        busy,
  output logic [1:0]  fault,
  output logic [31:0] retired
);

  // Handshakes: instr_req/mem_req stay high every cycle of FETCH/MEM; the
  // transfer completes on the first rising edge where the matching ack is 1.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_CBR, C_UBR, C_ILL
  } cls_e;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ret_q, ret_d;
  logic [1:0]  fault_q, fault_d;
  logic [3:0]  wait_q, wait_d;

  always_comb begin
    case (ir_q[31:26])
      6'd31, 6'd14, 6'd15, 6'd24, 6'd26, 6'd28: dec_cls = C_ALU;
      6'd32, 6'd34, 6'd40, 6'd42, 6'd58:        dec_cls = C_LOAD;
      6'd36, 6'd37, 6'd38, 6'd44, 6'd62:        dec_cls = C_STORE;
      6'd19:                                    dec_cls = C_CBR;
      6'd18:                                    dec_cls = C_UBR;
      default:                                  dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (instr_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 2'b10;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          fault_d = 2'b01;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_ALU:           state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default: begin
            ret_d   = ret_q + 32'd1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (cls_q == C_STORE) begin
            ret_d   = ret_q + 32'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 2'b11;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Only FETCH and MEM ever remain in place while waiting, so any state
    // change is an entry that restarts the count.
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 4'd0;
    end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
      ir_q    <= 32'd0;
      ret_q   <= 32'd0;
      fault_q <= 2'b00;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  assign instr_req = (state_q == S_FETCH);
  assign alu_en    = (state_q == S_EXEC);
  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && (cls_q == C_STORE);
  assign reg_we    = (state_q == S_WB);
  assign pc_inc    = (state_q == S_WB)
                   || ((state_q == S_MEM) && (cls_q == C_STORE) && mem_ack)
                   || ((state_q == S_EXEC) && (cls_q == C_CBR) && !alu_branch);
  assign pc_load   = (state_q == S_EXEC)
                   && (((cls_q == C_CBR) && alu_branch) || (cls_q == C_UBR));
  assign ir        = ir_q;
  assign state     = state_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign fault     = fault_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_upower_mc_control.sv
// Directed bench: each instruction is expanded into per-cycle stimulus and
// expected outputs; a negedge process checks every cycle plus literal pins.
module tb_upower_mc_control;

  localparam int TO = 15;

  typedef struct packed {
    logic        rst_n;
    logic        start;
    logic        instr_ack;
    logic [31:0] instr;
    logic        alu_branch;
    logic        mem_ack;
  } in_t;

  typedef struct packed {
    logic [2:0]  state;
    logic        instr_req;
    logic        alu_en;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        pc_inc;
    logic        pc_load;
    logic        busy;
    logic [1:0]  fault;
    logic [31:0] retired;
    logic [31:0] ir;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [31:0] ret;
    logic [1:0]  flt;
  } pin_t;

  localparam int CL_ALU = 0, CL_LOAD = 1, CL_STORE = 2, CL_CBR = 3, CL_UBR = 4, CL_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_ack, alu_branch, mem_ack;
  logic [31:0] instr;
  logic        instr_req, alu_en, mem_req, mem_we, reg_we, pc_inc, pc_load, busy;
  logic [31:0] ir, retired;
  logic [2:0]  state;
  logic [1:0]  fault;
  out_t        act;

  in_t              in_q[$];
  logic [OUT_W-1:0] exp_q[$];
  bit               chk_q[$];
  pin_t             pin_q[$];

  int total = 0;
  int bad   = 0;
  int vec_n = 0;
  bit running = 1'b0;

  logic [31:0] m_ir, m_ret;
  logic [1:0]  m_fault;

  upower_mc_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
    .alu_en(alu_en), .alu_branch(alu_branch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .ir(ir), .state(state), .busy(busy), .fault(fault), .retired(retired)
  );

  assign act = {state, instr_req, alu_en, mem_req, mem_we, reg_we, pc_inc,
                pc_load, busy, fault, retired, ir};

  // clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'd31, 6'd14, 6'd15, 6'd24, 6'd26, 6'd28: return CL_ALU;
      6'd32, 6'd34, 6'd40, 6'd42, 6'd58:        return CL_LOAD;
      6'd36, 6'd37, 6'd38, 6'd44, 6'd62:        return CL_STORE;
      6'd19:                                    return CL_CBR;
      6'd18:                                    return CL_UBR;
      default:                                  return CL_ILL;
    endcase
  endfunction

  function automatic out_t base(input logic [2:0] st);
    out_t o;
    o         = '0;
    o.state   = st;
    o.busy    = (st != 3'd0) && (st != 3'd6);
    o.fault   = m_fault;
    o.retired = m_ret;
    o.ir      = m_ir;
    return o;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.rst_n      = 1'b1;
    i.start      = 1'b0;
    i.instr_ack  = 1'($urandom_range(0, 1));
    i.instr      = $urandom;
    i.alu_branch = 1'($urandom_range(0, 1));
    i.mem_ack    = 1'($urandom_range(0, 1));
    return i;
  endfunction

  function automatic void step(input in_t i, input out_t o, input bit c);
    in_q.push_back(i);
    exp_q.push_back(o);
    chk_q.push_back(c);
  endfunction

  function automatic void model_reset();
    m_ir    = 32'd0;
    m_ret   = 32'd0;
    m_fault = 2'b00;
  endfunction

  function automatic void do_reset(input logic [2:0] st, input bit c);
    in_t i;
    i       = rand_in();
    i.rst_n = 1'b0;
    step(i, base(st), c);
    model_reset();
  endfunction

  function automatic void idle(input logic s);
    in_t i;
    i       = rand_in();
    i.start = s;
    step(i, base(3'd0), 1'b1);
  endfunction

  function automatic void halt(input int n);
    in_t i;
    for (int k = 0; k < n; k++) begin
      i       = rand_in();
      i.start = 1'b1;
      step(i, base(3'd6), 1'b1);
    end
  endfunction

  function automatic void pin(input logic [2:0] st, input logic [31:0] ret, input logic [1:0] f);
    pin_t p;
    p.idx = exp_q.size();
    p.st  = st;
    p.ret = ret;
    p.flt = f;
    pin_q.push_back(p);
  endfunction

  function automatic bit do_fetch(input logic [31:0] w, input int fw);
    in_t  i;
    out_t o;
    for (int k = 0; k <= fw; k++) begin
      if (k == TO) begin
        m_fault = 2'b10;
        return 1'b0;
      end
      i           = rand_in();
      i.instr_ack = (k == fw);
      if (k == fw) i.instr = w;
      o           = base(3'd1);
      o.instr_req = 1'b1;
      step(i, o, 1'b1);
    end
    m_ir = w;
    return 1'b1;
  endfunction

  // One instruction: fetch wait fw, memory wait mw, branch outcome br;
  // abort pulls reset in the first MEM cycle.
  function automatic void do_instr(input logic [31:0] w, input int fw, input int mw,
                                   input logic br, input bit abort);
    in_t  i;
    out_t o;
    int   cl;
    if (!do_fetch(w, fw)) return;
    cl = cls_of(w[31:26]);
    step(rand_in(), base(3'd2), 1'b1);
    if (cl == CL_ILL) begin
      m_fault = 2'b01;
      return;
    end
    i            = rand_in();
    i.alu_branch = br;
    o            = base(3'd3);
    o.alu_en     = 1'b1;
    if (cl == CL_CBR) begin
      o.pc_load = br;
      o.pc_inc  = !br;
    end
    if (cl == CL_UBR) o.pc_load = 1'b1;
    step(i, o, 1'b1);
    if (cl == CL_CBR || cl == CL_UBR) begin
      m_ret = m_ret + 32'd1;
      return;
    end
    if (cl == CL_LOAD || cl == CL_STORE) begin
      for (int k = 0; k <= mw; k++) begin
        if (k == TO) begin
          m_fault = 2'b11;
          return;
        end
        i         = rand_in();
        o         = base(3'd4);
        o.mem_req = 1'b1;
        o.mem_we  = (cl == CL_STORE);
        if (abort) begin
          i.rst_n   = 1'b0;
          i.mem_ack = 1'b0;
          step(i, o, 1'b1);
          model_reset();
          return;
        end
        i.mem_ack = (k == mw);
        o.pc_inc  = (k == mw) && (cl == CL_STORE);
        step(i, o, 1'b1);
      end
      if (cl == CL_STORE) begin
        m_ret = m_ret + 32'd1;
        return;
      end
    end
    o        = base(3'd5);
    o.reg_we = 1'b1;
    o.pc_inc = 1'b1;
    step(rand_in(), o, 1'b1);
    m_ret = m_ret + 32'd1;
  endfunction

  function automatic logic [31:0] op_word(input logic [5:0] op);
    return {op, 26'($urandom)};
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, vec_n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (running) begin
      out_t e;
      bit   c;
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      if (c) begin
        check("state",     32'(act.state),     32'(e.state));
        check("instr_req", 32'(act.instr_req), 32'(e.instr_req));
        check("alu_en",    32'(act.alu_en),    32'(e.alu_en));
        check("mem_req",   32'(act.mem_req),   32'(e.mem_req));
        check("mem_we",    32'(act.mem_we),    32'(e.mem_we));
        check("reg_we",    32'(act.reg_we),    32'(e.reg_we));
        check("pc_inc",    32'(act.pc_inc),    32'(e.pc_inc));
        check("pc_load",   32'(act.pc_load),   32'(e.pc_load));
        check("busy",      32'(act.busy),      32'(e.busy));
        check("fault",     32'(act.fault),     32'(e.fault));
        check("retired",   act.retired,        e.retired);
        check("ir",        act.ir,             e.ir);
      end
      if (pin_q.size() > 0 && pin_q[0].idx == vec_n) begin
        check("pin_state",   32'(state), 32'(pin_q[0].st));
        check("pin_retired", retired,    pin_q[0].ret);
        check("pin_fault",   32'(fault), 32'(pin_q[0].flt));
        void'(pin_q.pop_front());
      end
      vec_n++;
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input in_t i);
    rst_n      = i.rst_n;
    start      = i.start;
    instr_ack  = i.instr_ack;
    instr      = i.instr;
    alu_branch = i.alu_branch;
    mem_ack    = i.mem_ack;
  endtask

  task automatic build();
    model_reset();
    do_reset(3'd0, 1'b0);
    do_reset(3'd0, 1'b1);
    pin(3'd0, 32'd0, 2'b00);
    idle(1'b0);
    idle(1'b1);
    do_instr(32'h7C221A14, 0, 0, 1'b0, 1'b0);
    pin(3'd1, 32'd1, 2'b00);
    do_instr(op_word(6'd32), 1, 3, 1'b0, 1'b0);
    pin(3'd1, 32'd2, 2'b00);
    do_instr(op_word(6'd36), 0, 2, 1'b0, 1'b0);
    pin(3'd1, 32'd3, 2'b00);
    do_instr(op_word(6'd19), 0, 0, 1'b1, 1'b0);
    do_instr(op_word(6'd19), 2, 0, 1'b0, 1'b0);
    do_instr(op_word(6'd18), 0, 0, 1'b0, 1'b0);
    pin(3'd1, 32'd6, 2'b00);
    do_instr(op_word(6'd28), TO - 1, 0, 1'b0, 1'b0);
    pin(3'd1, 32'd7, 2'b00);
    do_instr(op_word(6'd58), 0, TO - 1, 1'b0, 1'b0);
    pin(3'd1, 32'd8, 2'b00);
    do_instr(op_word(6'd62), 0, 0, 1'b0, 1'b0);
    do_instr(op_word(6'd44), 0, 0, 1'b0, 1'b1);
    pin(3'd0, 32'd0, 2'b00);
    idle(1'b0);
    idle(1'b1);
    do_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0);
    pin(3'd6, 32'd0, 2'b01);
    halt(3);
    do_reset(3'd6, 1'b1);
    idle(1'b1);
    do_instr(op_word(6'd31), 20, 0, 1'b0, 1'b0);
    pin(3'd6, 32'd0, 2'b10);
    halt(3);
    do_reset(3'd6, 1'b1);
    idle(1'b1);
    do_instr(op_word(6'd34), 0, 20, 1'b0, 1'b0);
    pin(3'd6, 32'd0, 2'b11);
    halt(2);
    do_reset(3'd6, 1'b1);
    idle(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ack = 1'b0; instr = '0;
    alu_branch = 1'b0; mem_ack = 1'b0;
    build();
    while (in_q.size() > 0) begin
      @(posedge clk);
      #1;
      apply(in_q.pop_front());
      running = 1'b1;
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    if (pin_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pins_left got=%0d want=0", pin_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
